// File: rtl/bit_pipeline_pkg.sv
// Shared defaults for the bit_pipeline elastic register pipeline.
package bit_pipeline_pkg;

  localparam int DEFAULT_DATA_SIZE  = 8;
  localparam int DEFAULT_PIPE_DEPTH = 3;
  localparam int DEFAULT_COUNT_SIZE = 16;

endpackage

// File: rtl/bit_pipeline_stage.sv
// One pipeline stage: a data register plus valid flag that moves only when advanced.
module bit_pipeline_stage
  import bit_pipeline_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_advance,
  input  logic                 i_valid,
  input  logic [DATA_SIZE-1:0] i_data,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_data
);

  logic                 r_valid;
  logic [DATA_SIZE-1:0] r_data;

  // Flush drops only the valid flag; the data register keeps its last contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_advance) begin
        r_valid <= i_valid;
      end
      if (i_advance && i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/bit_pipeline.sv
// Elastic valid/ready register pipeline with bubble collapse, flush and an optional
// output-handshake counter built only when BIT_PIPELINE_COUNT_EN is defined.
module bit_pipeline
  import bit_pipeline_pkg::*;
#(
  parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
  parameter int PIPE_DEPTH = DEFAULT_PIPE_DEPTH,
  parameter int COUNT_SIZE = DEFAULT_COUNT_SIZE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic [DATA_SIZE-1:0]  DATA_IN,
  input  logic                  DATA_IN_VALID,
  output logic                  DATA_IN_READY,
  output logic [DATA_SIZE-1:0]  DATA_OUT,
  output logic                  DATA_OUT_VALID,
  input  logic                  DATA_OUT_READY,
  output logic [COUNT_SIZE-1:0] TRANSFER_COUNT
);

  logic [PIPE_DEPTH-1:0] w_valid;
  logic [DATA_SIZE-1:0]  w_data [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] w_advance;
  logic                  w_in_ready;
  logic                  w_in_hs;

  // A stage may move when any stage at or downstream of it is empty, or the sink takes
  // a word; written as a flat OR per stage so no signal depends on its own bits.
  always_comb begin
    w_advance = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      logic w_acc;
      w_acc = DATA_OUT_READY;
      for (int j = i; j < PIPE_DEPTH; j++) begin
        w_acc = w_acc | ~w_valid[j];
      end
      w_advance[i] = w_acc;
    end
  end

  assign w_in_ready = w_advance[0] & ~FLUSH & ~RST;
  assign w_in_hs    = DATA_IN_VALID & w_in_ready;

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
    logic                 w_stage_valid;
    logic [DATA_SIZE-1:0] w_stage_data;

    if (g == 0) begin : g_head
      assign w_stage_valid = w_in_hs;
      assign w_stage_data  = DATA_IN;
    end else begin : g_body
      assign w_stage_valid = w_valid[g-1];
      assign w_stage_data  = w_data[g-1];
    end

    bit_pipeline_stage #(
      .DATA_SIZE (DATA_SIZE)
    ) u_stage (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_flush   (FLUSH),
      .i_advance (w_advance[g]),
      .i_valid   (w_stage_valid),
      .i_data    (w_stage_data),
      .o_valid   (w_valid[g]),
      .o_data    (w_data[g])
    );
  end

  assign DATA_IN_READY  = w_in_ready;
  assign DATA_OUT       = w_data[PIPE_DEPTH-1];
  assign DATA_OUT_VALID = w_valid[PIPE_DEPTH-1];

`ifdef BIT_PIPELINE_COUNT_EN
  logic                  w_out_hs;
  logic [COUNT_SIZE-1:0] r_count;

  assign w_out_hs = w_valid[PIPE_DEPTH-1] & DATA_OUT_READY;

  // Output handshakes still count in a flush cycle; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (w_out_hs) begin
      r_count <= r_count + COUNT_SIZE'(1);
    end
  end

  assign TRANSFER_COUNT = r_count;
`else
  assign TRANSFER_COUNT = '0;
`endif

endmodule

// File: tb/tb_bit_pipeline.sv
// Scoreboard bench for bit_pipeline (DATA_SIZE=8, PIPE_DEPTH=3, COUNT_SIZE=4); counter
// expectations follow whether BIT_PIPELINE_COUNT_EN is defined.
module tb_bit_pipeline;

  logic       CLK = 1'b0;
  logic       RST;
  logic       FLUSH;
  logic [7:0] DATA_IN;
  logic       DATA_IN_VALID;
  logic       DATA_IN_READY;
  logic [7:0] DATA_OUT;
  logic       DATA_OUT_VALID;
  logic       DATA_OUT_READY;
  logic [3:0] TRANSFER_COUNT;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } expT;

  expT expQ[$];
  int  cyc        = 0;
  int  passCount  = 0;
  int  checkCount = 0;

  bit_pipeline #(
    .DATA_SIZE  (8),
    .PIPE_DEPTH (3),
    .COUNT_SIZE (4)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .FLUSH          (FLUSH),
    .DATA_IN        (DATA_IN),
    .DATA_IN_VALID  (DATA_IN_VALID),
    .DATA_IN_READY  (DATA_IN_READY),
    .DATA_OUT       (DATA_OUT),
    .DATA_OUT_VALID (DATA_OUT_VALID),
    .DATA_OUT_READY (DATA_OUT_READY),
    .TRANSFER_COUNT (TRANSFER_COUNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [3:0] expCount(input int n);
`ifdef BIT_PIPELINE_COUNT_EN
    return 4'(n % 16);
`else
    return 4'(0 * n);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ordy,
                               input logic fl, input logic rst);
    DATA_IN_VALID  = v;
    DATA_IN        = d;
    DATA_OUT_READY = ordy;
    FLUSH          = fl;
    RST            = rst;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic pushExp(input logic [7:0] d, input int when);
    expT e;
    e.data = d;
    e.cyc  = when;
    expQ.push_back(e);
  endtask

  // Monitor: every output handshake must match the oldest expected word (and its cycle).
  always @(negedge CLK) begin
    if (RST === 1'b0 && DATA_OUT_VALID === 1'b1 && DATA_OUT_READY === 1'b1) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_output: got 0x%0h, expected no word (cycle %0d)", DATA_OUT, cyc);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("out_data", 32'(DATA_OUT), 32'(e.data));
        if (e.cyc >= 0) checkOutput("out_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("ready_in_reset", 32'(DATA_IN_READY), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_valid", 32'(DATA_OUT_VALID), 32'd0);
    checkOutput("reset_data", 32'(DATA_OUT), 32'd0);
    checkOutput("reset_count", 32'(TRANSFER_COUNT), 32'd0);
    checkOutput("reset_ready_after", 32'(DATA_IN_READY), 32'd1);
    nextCycle();

    // Streaming 0x01..0x05, latency 3
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("stream_ready", 32'(DATA_IN_READY), 32'd1);
      pushExp(8'(i), cyc + 3);
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      nextCycle();
    end
    checkOutput("stream_drained", 32'(expQ.size()), 32'd0);
    checkOutput("stream_count", 32'(TRANSFER_COUNT), 32'(expCount(5)));

    // Backpressure 0xA0..0xA5
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
      checkOutput("bp_ready", 32'(DATA_IN_READY), (i < 3) ? 32'd1 : 32'd0);
      if (i < 3) begin
        pushExp(8'(8'hA0 + i), -1);
      end else begin
        checkOutput("bp_hold_data", 32'(DATA_OUT), 32'hA0);
        checkOutput("bp_hold_valid", 32'(DATA_OUT_VALID), 32'd1);
      end
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      nextCycle();
    end
    checkOutput("bp_drained", 32'(expQ.size()), 32'd0);
    checkOutput("bp_count", 32'(TRANSFER_COUNT), 32'(expCount(8)));

    // Bubble collapse: 0x66 must follow 0x55 on the very next cycle after release
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    checkOutput("bub_ready0", 32'(DATA_IN_READY), 32'd1);
    pushExp(8'h55, cyc + 4);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    checkOutput("bub_ready2", 32'(DATA_IN_READY), 32'd1);
    pushExp(8'h66, cyc + 3);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("bub_stall_data", 32'(DATA_OUT), 32'h55);
    checkOutput("bub_ready3", 32'(DATA_IN_READY), 32'd1);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      nextCycle();
    end
    checkOutput("bub_drained", 32'(expQ.size()), 32'd0);
    checkOutput("bub_count", 32'(TRANSFER_COUNT), 32'(expCount(10)));

    // Flush with stalled output: valids clear, data held, 0x77 rejected
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
      pushExp(8'(8'hB0 + i), -1);
      nextCycle();
    end
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_ready", 32'(DATA_IN_READY), 32'd0);
    nextCycle();
    expQ.delete();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_valid", 32'(DATA_OUT_VALID), 32'd0);
    checkOutput("flush_data_kept", 32'(DATA_OUT), 32'hB1);
    checkOutput("flush_ready_after", 32'(DATA_IN_READY), 32'd1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      nextCycle();
    end
    checkOutput("flush_count", 32'(TRANSFER_COUNT), 32'(expCount(10)));

    // Flush coinciding with an output handshake: that word still completes and counts
    applyStimulus(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0);
    pushExp(8'hC1, cyc + 3);
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("flushhs_valid", 32'(DATA_OUT_VALID), 32'd1);
    nextCycle();
    expQ.delete();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("flushhs_valid_after", 32'(DATA_OUT_VALID), 32'd0);
    checkOutput("flushhs_count", 32'(TRANSFER_COUNT), 32'(expCount(11)));
    nextCycle();

    // Reset, then 17 handshakes to wrap the 4-bit counter
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    nextCycle();
    expQ.delete();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("rst2_count", 32'(TRANSFER_COUNT), 32'd0);
    nextCycle();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0);
      pushExp(8'(8'h30 + i), cyc + 3);
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      nextCycle();
    end
    checkOutput("wrap_drained", 32'(expQ.size()), 32'd0);
    checkOutput("wrap_count", 32'(TRANSFER_COUNT), 32'(expCount(17)));
    checkOutput("wrap_stale_data", 32'(DATA_OUT), 32'h40);

    // Reset mid-stream discards in-flight words and clears data and counter
    applyStimulus(1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
    pushExp(8'h21, cyc + 3);
    nextCycle();
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    pushExp(8'h22, cyc + 3);
    nextCycle();
    applyStimulus(1'b1, 8'h23, 1'b1, 1'b0, 1'b1);
    checkOutput("midrst_ready", 32'(DATA_IN_READY), 32'd0);
    nextCycle();
    expQ.delete();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_count", 32'(TRANSFER_COUNT), 32'd0);
    checkOutput("midrst_data", 32'(DATA_OUT), 32'd0);
    checkOutput("midrst_valid", 32'(DATA_OUT_VALID), 32'd0);
    checkOutput("midrst_ready_after", 32'(DATA_IN_READY), 32'd1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      nextCycle();
    end
    checkOutput("final_count", 32'(TRANSFER_COUNT), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bit_pipeline.md
BIT_PIPELINE -- requirements
Module: bit_pipeline

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, meaning the data bit-vector width (1 or more).
REQ-002 SHALL have parameter PIPE_DEPTH, default 3, meaning the number of register stages (1 or more).
REQ-003 SHALL have parameter COUNT_SIZE, default 16, meaning the transfer counter width.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port FLUSH, input, 1 bit: discard all in-flight data.
REQ-007 SHALL have port DATA_IN, input, DATA_SIZE bits: upstream data.
REQ-008 SHALL have port DATA_IN_VALID, input, 1 bit: upstream data present.
REQ-009 SHALL have port DATA_IN_READY, output, 1 bit: the block accepts this cycle.
REQ-010 SHALL have port DATA_OUT, output, DATA_SIZE bits: data from the last stage.
REQ-011 SHALL have port DATA_OUT_VALID, output, 1 bit: the last stage holds valid data.
REQ-012 SHALL have port DATA_OUT_READY, input, 1 bit: downstream accepts.
REQ-013 SHALL have port TRANSFER_COUNT, output, COUNT_SIZE bits: count of completed output handshakes.

Function
REQ-014 Each stage i SHALL hold a data register and a valid flag; advance(i) = !valid(i) | advance(i+1), where advance(last) = !valid(last) | DATA_OUT_READY.
REQ-015 DATA_IN_READY SHALL equal advance(0) & !FLUSH, combinationally.
REQ-016 An input handshake (DATA_IN_VALID & DATA_IN_READY) SHALL load stage 0 at the next edge; a stage that advances without new data SHALL clear its valid flag.
REQ-017 Latency with no stall SHALL be exactly PIPE_DEPTH cycles, input handshake to DATA_OUT_VALID.
REQ-018 Throughput SHALL be one word per cycle while DATA_OUT_READY=1.
REQ-019 Bubbles SHALL collapse: a stall SHALL stop only stages that are valid and blocked; empty stages upstream of it SHALL keep filling.
REQ-020 A stage that does not advance SHALL hold its data unchanged, so DATA_OUT stays stable while DATA_OUT_VALID=1 and DATA_OUT_READY=0.
REQ-021 Order SHALL be preserved; there SHALL be no duplication or loss except by FLUSH or RST.
REQ-022 When FLUSH=1, all valid flags SHALL clear at the next edge, and a same-cycle input SHALL NOT be accepted (DATA_IN_READY=0).
REQ-023 A same-cycle output handshake during FLUSH SHALL still complete and count.
REQ-024 Data registers SHALL NOT be cleared by FLUSH; only the valid flags SHALL be cleared.
REQ-025 TRANSFER_COUNT SHALL increment by 1 per output handshake and wrap from 2^COUNT_SIZE-1 to 0.

Reset
REQ-026 While RST=1 at an edge, all valid flags, all data registers, DATA_OUT and TRANSFER_COUNT SHALL become 0; RST SHALL take priority over FLUSH and handshakes.
REQ-027 During RST=1, DATA_IN_READY SHALL be 0.
REQ-028 Reset mid-stream SHALL discard all in-flight words; the first cycle after RST is deasserted SHALL show DATA_OUT_VALID=0 and DATA_IN_READY=1.

Configuration
REQ-029 Macro BIT_PIPELINE_COUNT_EN defined: the TRANSFER_COUNT counter SHALL be built per REQ-025.
REQ-030 Macro BIT_PIPELINE_COUNT_EN undefined: no counter logic SHALL be built, the TRANSFER_COUNT port SHALL remain, and it SHALL be tied to 0.

Structure
REQ-031 Package bit_pipeline_pkg SHALL hold the DATA_SIZE, PIPE_DEPTH and COUNT_SIZE default constants.
REQ-032 One sub-module, bit_pipeline_stage, SHALL implement a single data/valid register with an advance input; it SHALL be instantiated PIPE_DEPTH times in a generate loop.

Verification (DATA_SIZE=8, PIPE_DEPTH=3, COUNT_SIZE=4)
REQ-033 Streaming: 0x01..0x05 on consecutive cycles with DATA_OUT_READY=1 -> 0x01 appears 3 cycles after its handshake, then 0x02..0x05 on consecutive cycles; TRANSFER_COUNT=5.
REQ-034 Backpressure: hold DATA_OUT_READY=0 and drive 0xA0..0xA5 -> 3 words accepted, DATA_IN_READY falls, DATA_OUT holds 0xA0; release -> 0xA0..0xA2 drain in order.
REQ-035 Bubble collapse: one word 0x55, stall the output, then feed 0x66 two cycles later -> 0x66 reaches stage 1 behind 0x55 without waiting for the stall to release.
REQ-036 Flush: 3 words in flight, FLUSH=1 for one cycle with DATA_IN_VALID=1 and DATA_IN=0x77 -> all valid flags clear, 0x77 is not accepted, DATA_OUT_VALID=0 on the next cycle.
REQ-037 Reset and wrap: 17 output handshakes -> TRANSFER_COUNT=1; then RST mid-stream -> TRANSFER_COUNT=0, DATA_OUT=0x00, DATA_OUT_VALID=0.
REQ-038 Configuration: build without BIT_PIPELINE_COUNT_EN and rerun REQ-033 -> identical data behaviour, TRANSFER_COUNT=0 throughout.
